// File: rtl/memref_exec_unit.sv
// memref_exec_unit
//   Multi-cycle executor for accumulator memory-reference instructions
//   (LOAD/STORE/ADD/SUB/AND/OR/XOR/CLEAR X). Holds AC, MAR and MBR.
//   A single sequencing FSM drives a synchronous-read memory port.
//   Optional feature macro: MEMOP_FLAGS_EN adds zero/neg/carry flags.
//   The flags are updated on EXEC edges only.
module memref_exec_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr_x,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ac_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEMOP_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              neg_flag,
  output logic              carry_flag
`endif
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WR   = 3'd4
  } state_t;

  state_t            state_r;
  logic [2:0]        op_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] mbr_r;
  logic [DATA_W-1:0] ac_r;

  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_carry_s;

  // The memory port mirrors the architectural registers directly.
  assign ac_out    = ac_r;
  assign mem_addr  = mar_r;
  assign mem_wdata = ac_r;

  // ALU: compute the next AC from the latched op, AC and MBR. Arithmetic wraps modulo 2**DATA_W.
  always_comb begin
    sum_s       = {1'b0, ac_r} + {1'b0, mbr_r};
    alu_res_s   = ac_r;
    alu_carry_s = 1'b0;
    case (op_r)
      OP_LOAD:  alu_res_s = mbr_r;
      OP_ADD: begin
        alu_res_s   = sum_s[DATA_W-1:0];
        alu_carry_s = sum_s[DATA_W];
      end
      OP_SUB: begin
        alu_res_s   = ac_r - mbr_r;
        alu_carry_s = (ac_r < mbr_r) ? 1'b1 : 1'b0;
      end
      OP_AND:   alu_res_s = ac_r & mbr_r;
      OP_OR:    alu_res_s = ac_r | mbr_r;
      OP_XOR:   alu_res_s = ac_r ^ mbr_r;
      OP_CLEAR: alu_res_s = {DATA_W{1'b0}};
      default: begin
        alu_res_s   = ac_r;
        alu_carry_s = 1'b0;
      end
    endcase
  end

  // Sequencer: a single FSM that owns every register. The strobes and done are registered one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      op_r       <= 3'b000;
      mar_r      <= {ADDR_W{1'b0}};
      mbr_r      <= {DATA_W{1'b0}};
      ac_r       <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
`ifdef MEMOP_FLAGS_EN
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      carry_flag <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Start is also sampled here in the done cycle, so back-to-back ops need no gap.
          if (start) begin
            mar_r <= addr_x;
            op_r  <= op;
            busy  <= 1'b1;
            case (op)
              OP_STORE: begin
                state_r <= ST_WR;
                mem_we  <= 1'b1;
              end
              OP_CLEAR: state_r <= ST_EXEC;
              default: begin
                state_r <= ST_RD;
                mem_re  <= 1'b1;
              end
            endcase
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RD: begin
          // The memory samples the address on this edge and returns data for CAP.
          state_r <= ST_CAP;
        end
        ST_CAP: begin
          mbr_r   <= mem_rdata;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          ac_r       <= alu_res_s;
`ifdef MEMOP_FLAGS_EN
          zero_flag  <= (alu_res_s == {DATA_W{1'b0}}) ? 1'b1 : 1'b0;
          neg_flag   <= alu_res_s[DATA_W-1];
          carry_flag <= alu_carry_s;
`endif
          done       <= 1'b1;
          busy       <= 1'b0;
          state_r    <= ST_IDLE;
        end
        ST_WR: begin
          // The write strobe was raised on entry. The memory commits the word on this edge.
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef MEMOP_FLAGS_EN
  // The carry is only consumed when the flags are built in.
  logic unused_carry_s;
  assign unused_carry_s = alu_carry_s;
`endif

endmodule

// File: tb/tb_memref_exec_unit.sv
// Directed self-checking bench for memref_exec_unit with a synchronous-read memory model.
module tb_memref_exec_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [13:0] addr_x;
  logic        busy;
  logic        done;
  logic [15:0] ac_out;
  logic [13:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef MEMOP_FLAGS_EN
  logic        zero_flag;
  logic        neg_flag;
  logic        carry_flag;
`endif

  int total;
  int bad;

  logic [15:0] mem [0:16383];

  memref_exec_unit #(.DATA_W(16), .ADDR_W(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .addr_x    (addr_x),
    .busy      (busy),
    .done      (done),
    .ac_out    (ac_out),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEMOP_FLAGS_EN
    ,
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .carry_flag(carry_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data for a read appears after the edge that sees mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Issue one op and follow it to done. The counts are taken 1 time unit after each edge.
  task automatic issue(input logic [2:0] o, input logic [13:0] a, input bit hold,
                       output int lat, output int re_cnt, output int we_cnt,
                       output int both_cnt, output logic acc_busy,
                       output logic [13:0] wa, output logic [15:0] wd);
    lat = 0; re_cnt = 0; we_cnt = 0; both_cnt = 0; wa = 14'h0; wd = 16'h0;
    @(negedge clk);
    start = 1'b1; op = o; addr_x = a;
    @(posedge clk);
    #1;
    acc_busy = busy;
    if (hold) begin
      op = 3'b011;
      addr_x = a ^ 14'h0001;
    end else begin
      start = 1'b0;
    end
    while (1) begin
      if (mem_re) re_cnt++;
      if (mem_we) begin
        we_cnt++;
        wa = mem_addr;
        wd = mem_wdata;
      end
      if (mem_re && mem_we) both_cnt++;
      if (done === 1'b1) break;
      if (lat >= 20) break;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL timeout op=%0d: done=%b after %0d edges, required 1", o, done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'b000; addr_x = 14'h0;
    #23;
    total++;
    if ({busy, done, mem_re, mem_we} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b required 0000", {busy, done, mem_re, mem_we});
    end
    total++;
    if (ac_out !== 16'h0000 || mem_addr !== 14'h0000) begin
      bad++; $display("FAIL reset_regs: ac=%h addr=%h required 0", ac_out, mem_addr);
    end
`ifdef MEMOP_FLAGS_EN
    total++;
    if ({zero_flag, neg_flag, carry_flag} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b required 000", {zero_flag, neg_flag, carry_flag});
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_add();
    int lat, rc, wc, bc; logic ab; logic [13:0] wa; logic [15:0] wd;
    mem[14'h0010] = 16'h1234;
    mem[14'h0011] = 16'h0001;
    issue(3'b000, 14'h0010, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 3 || rc !== 1 || wc !== 0 || ab !== 1'b1) begin
      bad++; $display("FAIL load_timing: lat=%0d re=%0d we=%0d busy=%b required 3 1 0 1", lat, rc, wc, ab);
    end
    total++;
    if (ac_out !== 16'h1234) begin bad++; $display("FAIL load_ac: got %h required 1234", ac_out); end
    issue(3'b010, 14'h0011, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 3 || rc !== 1 || bc !== 0) begin
      bad++; $display("FAIL add_timing: lat=%0d re=%0d both=%0d required 3 1 0", lat, rc, bc);
    end
    total++;
    if (ac_out !== 16'h1235) begin bad++; $display("FAIL add_ac: got %h required 1235", ac_out); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: busy=%b required 0", busy); end
  endtask

  task automatic test_wrap_flags();
    int lat, rc, wc, bc; logic ab; logic [13:0] wa; logic [15:0] wd;
    mem[14'h0030] = 16'hFFFF;
    mem[14'h0031] = 16'h0002;
    mem[14'h0032] = 16'h0001;
    issue(3'b000, 14'h0030, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    issue(3'b010, 14'h0031, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'h0001) begin bad++; $display("FAIL add_wrap: got %h required 0001", ac_out); end
`ifdef MEMOP_FLAGS_EN
    total++;
    if ({zero_flag, neg_flag, carry_flag} !== 3'b001) begin
      bad++; $display("FAIL add_flags: znc=%b required 001", {zero_flag, neg_flag, carry_flag});
    end
`endif
    issue(3'b011, 14'h0032, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'h0000) begin bad++; $display("FAIL sub_zero: got %h required 0000", ac_out); end
`ifdef MEMOP_FLAGS_EN
    total++;
    if ({zero_flag, neg_flag, carry_flag} !== 3'b100) begin
      bad++; $display("FAIL sub_flags: znc=%b required 100", {zero_flag, neg_flag, carry_flag});
    end
`endif
    issue(3'b011, 14'h0032, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'hFFFF) begin bad++; $display("FAIL sub_borrow: got %h required ffff", ac_out); end
`ifdef MEMOP_FLAGS_EN
    total++;
    if ({zero_flag, neg_flag, carry_flag} !== 3'b011) begin
      bad++; $display("FAIL borrow_flags: znc=%b required 011", {zero_flag, neg_flag, carry_flag});
    end
`endif
  endtask

  task automatic test_logic_clear();
    int lat, rc, wc, bc; logic ab; logic [13:0] wa; logic [15:0] wd;
    mem[14'h0040] = 16'h0F0F;
    mem[14'h0041] = 16'hF000;
    mem[14'h0042] = 16'h00FF;
    issue(3'b100, 14'h0040, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'h0F0F) begin bad++; $display("FAIL and_ac: got %h required 0f0f", ac_out); end
    issue(3'b101, 14'h0041, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'hFF0F) begin bad++; $display("FAIL or_ac: got %h required ff0f", ac_out); end
    issue(3'b110, 14'h0042, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'hFFF0) begin bad++; $display("FAIL xor_ac: got %h required fff0", ac_out); end
    issue(3'b111, 14'h0042, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 1 || rc !== 0 || wc !== 0 || ac_out !== 16'h0000) begin
      bad++; $display("FAIL clear: lat=%0d re=%0d we=%0d ac=%h required 1 0 0 0000", lat, rc, wc, ac_out);
    end
  endtask

  task automatic test_store();
    int lat, rc, wc, bc; logic ab; logic [13:0] wa; logic [15:0] wd;
    mem[14'h0043] = 16'hABCD;
    mem[14'h0020] = 16'h0000;
    issue(3'b000, 14'h0043, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    issue(3'b001, 14'h0020, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 1 || wc !== 1 || rc !== 0) begin
      bad++; $display("FAIL store_timing: lat=%0d we=%0d re=%0d required 1 1 0", lat, wc, rc);
    end
    total++;
    if (wa !== 14'h0020 || wd !== 16'hABCD) begin
      bad++; $display("FAIL store_bus: addr=%h data=%h required 0020 abcd", wa, wd);
    end
    total++;
    if (mem[14'h0020] !== 16'hABCD) begin
      bad++; $display("FAIL store_mem: got %h required abcd", mem[14'h0020]);
    end
    issue(3'b111, 14'h0000, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    issue(3'b000, 14'h0020, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ac_out !== 16'hABCD) begin bad++; $display("FAIL store_reload: got %h required abcd", ac_out); end
  endtask

  task automatic test_busy_ignore();
    int lat, rc, wc, bc, extra; logic ab; logic [13:0] wa; logic [15:0] wd;
    issue(3'b010, 14'h0011, 1'b1, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 3 || rc !== 1) begin
      bad++; $display("FAIL hold_timing: lat=%0d re=%0d required 3 1", lat, rc);
    end
    total++;
    if (ac_out !== 16'hABCE) begin bad++; $display("FAIL hold_ac: got %h required abce", ac_out); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL hold_extra: got %0d stray cycles required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, rc, wc, bc; logic ab; logic [13:0] wa; logic [15:0] wd;
    issue(3'b000, 14'h0010, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    issue(3'b010, 14'h0011, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (ab !== 1'b1 || lat !== 3) begin
      bad++; $display("FAIL b2b_accept: busy=%b lat=%0d required 1 3", ab, lat);
    end
    total++;
    if (ac_out !== 16'h1235) begin bad++; $display("FAIL b2b_ac: got %h required 1235", ac_out); end
  endtask

  task automatic test_reset_mid();
    int lat, rc, wc, bc, stray; logic ab; logic [13:0] wa; logic [15:0] wd;
    @(negedge clk);
    start = 1'b1; op = 3'b100; addr_x = 14'h0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (mem_re !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_rd: re=%b busy=%b required 1 1", mem_re, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, mem_re, mem_we} !== 4'b0000 || ac_out !== 16'h0000 || mem_addr !== 14'h0000) begin
      bad++; $display("FAIL mid_reset: ctrl=%b ac=%h addr=%h required 0000 0 0",
                      {busy, done, mem_re, mem_we}, ac_out, mem_addr);
    end
    stray = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || mem_we !== 1'b0) stray++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    if (done !== 1'b0 || mem_we !== 1'b0) stray++;
    total++;
    if (stray !== 0) begin bad++; $display("FAIL mid_stray: got %0d required 0", stray); end
    issue(3'b100, 14'h0010, 1'b0, lat, rc, wc, bc, ab, wa, wd);
    total++;
    if (lat !== 3 || ac_out !== 16'h0000) begin
      bad++; $display("FAIL post_reset_and: lat=%0d ac=%h required 3 0000", lat, ac_out);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load_add();
    test_wrap_flags();
    test_logic_clear();
    test_store();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
